// File: rtl/packet_store_rb.sv
// Receive packet store: MAC bytes land in a circular buffer and are committed or rolled back at
// end of packet; committed lengths queue in a small FIFO that drives a length-then-data reader.
module packet_store_rb #(
  parameter int pDATA_W    = 8,
  parameter int pRB_ADDR_W = 14,
  parameter int pLEN_W     = 16,
  parameter int pLF_ADDR_W = 4,
  parameter int pMIN_LEN   = 64,
  parameter int pMAX_LEN   = 1518
) (
  input  logic               iclk,
  input  logic               i_rst,
  input  logic               idv,
  input  logic [pDATA_W-1:0] irx_d,
  input  logic               ilast,
  input  logic               icrc_err,
  output logic               olen_valid,
  output logic [pLEN_W-1:0]  olen,
  input  logic               iread_start,
  input  logic               ird_en,
  output logic               ord_valid,
  output logic [pDATA_W-1:0] ord_data,
  output logic               ord_last,
  output logic               obusy_rd,
  output logic [15:0]        opkt_cnt,
  output logic [15:0]        odrop_cnt
);
  localparam int RB_DEPTH = 2 ** pRB_ADDR_W;
  localparam int LF_DEPTH = 2 ** pLF_ADDR_W;
  localparam logic [pLEN_W:0]     MIN_LEN = (pLEN_W + 1)'(pMIN_LEN);
  localparam logic [pLEN_W:0]     MAX_LEN = (pLEN_W + 1)'(pMAX_LEN);
  localparam logic [pLF_ADDR_W:0] LF_FULL = (pLF_ADDR_W + 1)'(LF_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DISCARD} w_state_t;
  typedef enum logic {R_IDLE, R_READ} r_state_t;

  logic [pDATA_W-1:0] rb_mem [RB_DEPTH];
  logic [pLEN_W-1:0]  lf_mem [LF_DEPTH];

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  logic [pRB_ADDR_W-1:0] wr_spec_q, wr_spec_d, wr_cmt_q, wr_cmt_d, rd_ptr_q, rd_ptr_d;
  logic [pLEN_W-1:0]     len_q, len_d, remaining_q, remaining_d;
  logic [pLF_ADDR_W-1:0] lf_wr_q, lf_wr_d, lf_rd_q, lf_rd_d;
  logic [pLF_ADDR_W:0]   lf_cnt_q, lf_cnt_d;
  logic [1:0][15:0]      cnt_q, cnt_d;
  logic                  ord_valid_q, ord_last_q;
  logic [pDATA_W-1:0]    ord_data_q;

  logic [pRB_ADDR_W-1:0] wr_spec_inc;
  logic [pLEN_W:0]       len_inc;
  logic                  rb_full, too_long, lf_full, lf_empty;
  logic                  wr_en, lf_push, lf_pop, rd_fire, do_drop, do_commit;
  logic [1:0]            cnt_inc;

  // Full when one more word would make wr_spec catch up with rd_ptr (one slot always kept free).
  assign wr_spec_inc = wr_spec_q + 1'b1;
  assign rb_full     = (wr_spec_inc == rd_ptr_q);
  assign len_inc     = {1'b0, len_q} + 1'b1;
  assign too_long    = (len_inc > MAX_LEN);
  assign lf_full     = (lf_cnt_q == LF_FULL);
  assign lf_empty    = (lf_cnt_q == '0);

  always_comb begin
    w_state_d = w_state_q;
    wr_spec_d = wr_spec_q;
    wr_cmt_d  = wr_cmt_q;
    len_d     = len_q;
    wr_en     = 1'b0;
    do_drop   = 1'b0;
    do_commit = 1'b0;
    if (idv) begin
      case (w_state_q)
        W_IDLE, W_WRITE: begin
          if (rb_full || too_long) begin
            if (ilast) do_drop = 1'b1;
            else       w_state_d = W_DISCARD;
          end else begin
            wr_en     = 1'b1;
            wr_spec_d = wr_spec_inc;
            len_d     = len_inc[pLEN_W-1:0];
            w_state_d = W_WRITE;
            if (ilast) begin
              if (!icrc_err && (len_inc >= MIN_LEN) && !lf_full) do_commit = 1'b1;
              else                                                do_drop   = 1'b1;
            end
          end
        end
        W_DISCARD: if (ilast) do_drop = 1'b1;
        default:   w_state_d = W_IDLE;
      endcase
    end
    if (do_commit) begin
      wr_cmt_d  = wr_spec_inc;
      len_d     = '0;
      w_state_d = W_IDLE;
    end
    // Rolling back to the committed pointer discards everything the packet wrote.
    if (do_drop) begin
      wr_spec_d = wr_cmt_q;
      len_d     = '0;
      w_state_d = W_IDLE;
    end
  end

  assign lf_push    = do_commit;
  assign olen_valid = !lf_empty && (r_state_q == R_IDLE);
  assign olen       = olen_valid ? lf_mem[lf_rd_q] : '0;
  assign lf_pop     = olen_valid && iread_start;
  assign rd_fire    = (r_state_q == R_READ) && ird_en && (remaining_q != '0);

  always_comb begin
    r_state_d   = r_state_q;
    remaining_d = remaining_q;
    rd_ptr_d    = rd_ptr_q;
    case (r_state_q)
      R_IDLE: begin
        if (lf_pop) begin
          remaining_d = lf_mem[lf_rd_q];
          r_state_d   = R_READ;
        end
      end
      R_READ: begin
        if (rd_fire) begin
          rd_ptr_d    = rd_ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == {{(pLEN_W-1){1'b0}}, 1'b1}) r_state_d = R_IDLE;
        end else if (remaining_q == '0) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    lf_wr_d  = lf_push ? lf_wr_q + 1'b1 : lf_wr_q;
    lf_rd_d  = lf_pop ? lf_rd_q + 1'b1 : lf_rd_q;
    lf_cnt_d = lf_cnt_q;
    case ({lf_push, lf_pop})
      2'b10:   lf_cnt_d = lf_cnt_q + 1'b1;
      2'b01:   lf_cnt_d = lf_cnt_q - 1'b1;
      default: lf_cnt_d = lf_cnt_q;
    endcase
  end

  assign cnt_inc = {do_drop, do_commit};
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      assign cnt_d[gi] = (cnt_inc[gi] && (cnt_q[gi] != 16'hFFFF)) ? cnt_q[gi] + 16'd1 : cnt_q[gi];
    end
  endgenerate

  always_ff @(posedge iclk) begin
    if (i_rst) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      wr_spec_q   <= '0;
      wr_cmt_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      lf_wr_q     <= '0;
      lf_rd_q     <= '0;
      lf_cnt_q    <= '0;
      cnt_q       <= '0;
      ord_valid_q <= 1'b0;
      ord_last_q  <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      wr_spec_q   <= wr_spec_d;
      wr_cmt_q    <= wr_cmt_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      lf_wr_q     <= lf_wr_d;
      lf_rd_q     <= lf_rd_d;
      lf_cnt_q    <= lf_cnt_d;
      cnt_q       <= cnt_d;
      ord_valid_q <= rd_fire;
      ord_last_q  <= rd_fire && (remaining_q == {{(pLEN_W-1){1'b0}}, 1'b1});
    end
  end

  always_ff @(posedge iclk) begin
    if (wr_en) rb_mem[wr_spec_q] <= irx_d;
  end

  always_ff @(posedge iclk) begin
    if (lf_push) lf_mem[lf_wr_q] <= len_inc[pLEN_W-1:0];
  end

  always_ff @(posedge iclk) begin
    if (i_rst)        ord_data_q <= '0;
    else if (rd_fire) ord_data_q <= rb_mem[rd_ptr_q];
  end

  assign ord_valid = ord_valid_q;
  assign ord_data  = ord_data_q;
  assign ord_last  = ord_last_q;
  assign obusy_rd  = (r_state_q == R_READ);
  assign opkt_cnt  = cnt_q[0];
  assign odrop_cnt = cnt_q[1];
endmodule

// File: tb/tb_packet_store_rb.sv
// Bench for packet_store_rb: directed scenarios plus randomized traffic, checked every cycle
// against an occupancy/queue model of the packet store.
module tb_packet_store_rb;
  localparam int RB_W = 11;
  localparam int CAP  = 2 ** RB_W - 1;
  localparam int LF_N = 16;
  localparam int MINL = 64;
  localparam int MAXL = 1518;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0, idv = 1'b0, ilast = 1'b0, icrc_err = 1'b0;
  logic [7:0]  irx_d = '0;
  logic        iread_start = 1'b0, ird_en = 1'b0;
  logic        olen_valid, ord_valid, ord_last, obusy_rd;
  logic [15:0] olen, opkt_cnt, odrop_cnt;
  logic [7:0]  ord_data;

  packet_store_rb #(
    .pDATA_W(8), .pRB_ADDR_W(RB_W), .pLEN_W(16), .pLF_ADDR_W(4), .pMIN_LEN(MINL), .pMAX_LEN(MAXL)
  ) dut (
    .iclk(clk), .i_rst(i_rst), .idv(idv), .irx_d(irx_d), .ilast(ilast), .icrc_err(icrc_err),
    .olen_valid(olen_valid), .olen(olen), .iread_start(iread_start), .ird_en(ird_en),
    .ord_valid(ord_valid), .ord_data(ord_data), .ord_last(ord_last), .obusy_rd(obusy_rd),
    .opkt_cnt(opkt_cnt), .odrop_cnt(odrop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: buffer occupancy, in-flight packet bytes, committed lengths and bytes.
  logic [7:0] m_spec[$];
  logic [7:0] m_data[$];
  int         m_lenq[$];
  int         m_occ, m_rem, m_pkt, m_drop, m_popped = 0;
  bit         m_discard, m_reading, model_valid = 0;
  bit         exp_ov, exp_ol;
  logic [7:0] exp_od;
  int         rd_mode = 0, rd_target = 0;
  int         dut_lasts = 0;
  logic [7:0] dut_rd[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_spec.delete(); m_data.delete(); m_lenq.delete();
    m_occ = 0; m_rem = 0; m_pkt = 0; m_drop = 0;
    m_discard = 0; m_reading = 0;
    exp_ov = 0; exp_ol = 0; exp_od = '0;
    rd_target = m_popped;
  endfunction

  function automatic void model_drop();
    $display("pkt drop    len_written=%0d", m_spec.size());
    m_occ -= m_spec.size();
    m_spec.delete();
    m_discard = 0;
    if (m_drop < 65535) m_drop++;
  endfunction

  function automatic void model_commit();
    $display("pkt commit  len=%0d", m_spec.size());
    foreach (m_spec[i]) m_data.push_back(m_spec[i]);
    m_lenq.push_back(m_spec.size());
    m_spec.delete();
    if (m_pkt < 65535) m_pkt++;
  endfunction

  // One clock: check outputs against the model, drive new inputs, advance the model.
  task automatic step(input bit rst, input bit v, input logic [7:0] d, input bit l, input bit c);
    bit olv, pop, fire, full_start, rs, re;
    @(negedge clk);
    olv = (m_lenq.size() != 0) && !m_reading;
    if (model_valid) begin
      check_val("olen_valid", 32'(olen_valid), 32'(olv));
      if (olv) check_val("olen", 32'(olen), 32'(m_lenq[0]));
      check_val("busy_rd", 32'(obusy_rd), 32'(m_reading));
      check_val("ord_valid", 32'(ord_valid), 32'(exp_ov));
      if (exp_ov) begin
        check_val("ord_data", 32'(ord_data), 32'(exp_od));
        check_val("ord_last", 32'(ord_last), 32'(exp_ol));
      end
      check_val("pkt_cnt", 32'(opkt_cnt), 32'(m_pkt));
      check_val("drop_cnt", 32'(odrop_cnt), 32'(m_drop));
    end
    if (ord_valid === 1'b1) begin
      dut_rd.push_back(ord_data);
      if (ord_last === 1'b1) dut_lasts++;
    end
    rs = 0; re = 0;
    case (rd_mode)
      1: begin rs = ($urandom_range(0, 3) == 0); re = ($urandom_range(0, 3) != 0); end
      2: begin rs = (m_popped < rd_target); re = 1; end
      default: ;
    endcase
    i_rst = rst; idv = v; irx_d = d; ilast = v & l; icrc_err = v & l & c;
    iread_start = rs; ird_en = re;
    if (rst) begin
      model_reset();
      model_valid = 1;
    end else begin
      full_start = (m_lenq.size() == LF_N);
      pop  = rs && olv;
      fire = m_reading && re && (m_rem > 0);
      if (v) begin
        if (m_discard) begin
          if (l) model_drop();
        end else if (m_occ == CAP || m_spec.size() + 1 > MAXL) begin
          if (l) model_drop();
          else   m_discard = 1;
        end else begin
          m_spec.push_back(d);
          m_occ++;
          if (l) begin
            if (!c && m_spec.size() >= MINL && !full_start) model_commit();
            else                                            model_drop();
          end
        end
      end
      exp_ov = fire;
      exp_ol = 0;
      if (fire) begin
        exp_od = m_data.pop_front();
        exp_ol = (m_rem == 1);
        m_rem--;
        m_occ--;
        if (m_rem == 0) begin
          m_reading = 0;
          $display("read done   pkt_words_left_in_store=%0d", m_data.size());
        end
      end
      if (pop) begin
        m_reading = 1;
        m_rem = m_lenq.pop_front();
        m_popped++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    repeat (3) step(1, 0, 8'h00, 0, 0);
  endtask

  task automatic send_packet(input int len, input bit crc, input bit incr, input bit with_last,
                             input int gap);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      if (gap > 0 && $urandom_range(0, gap - 1) == 0) idle(1);
      d = incr ? 8'(i) : 8'($urandom_range(0, 255));
      step(0, 1, d, with_last && (i == len - 1), crc);
    end
  endtask

  task automatic read_pkts(input int n);
    int goal;
    goal = dut_lasts + n + (m_reading ? 1 : 0) + ((exp_ov && exp_ol) ? 1 : 0);
    rd_target = m_popped + n;
    rd_mode = 2;
    for (int k = 0; k < 6000 && dut_lasts < goal; k++) idle(1);
    check_val("rd_pkts_seen", 32'(dut_lasts), 32'(goal));
    rd_mode = 0;
    idle(2);
  endtask

  initial begin
    // Reset state
    do_reset();
    idle(1);
    check_val("rst_ord_data", 32'(ord_data), 32'h0);
    check_val("rst_olen", 32'(olen), 32'h0);
    check_val("rst_ord_valid", 32'(ord_valid), 32'h0);

    // 1: single 64-word packet, counting pattern, then read back
    send_packet(64, 0, 1, 1, 0);
    idle(2);
    check_val("t1_pkt_cnt", 32'(opkt_cnt), 32'd1);
    check_val("t1_olen", 32'(olen), 32'd64);
    dut_rd.delete();
    read_pkts(1);
    check_val("t1_rd_words", 32'(dut_rd.size()), 32'd64);
    if (dut_rd.size() == 64) begin
      check_val("t1_first", 32'(dut_rd[0]), 32'h00);
      check_val("t1_last", 32'(dut_rd[63]), 32'h3F);
    end

    // 2: CRC-bad packet rolled back, good packet reuses its space
    do_reset();
    send_packet(64, 1, 0, 1, 0);
    send_packet(100, 0, 1, 1, 0);
    idle(2);
    check_val("t2_drop_cnt", 32'(odrop_cnt), 32'd1);
    check_val("t2_olen", 32'(olen), 32'd100);
    dut_rd.delete();
    read_pkts(1);
    check_val("t2_rd_words", 32'(dut_rd.size()), 32'd100);
    if (dut_rd.size() == 100) begin
      check_val("t2_first", 32'(dut_rd[0]), 32'h00);
      check_val("t2_last", 32'(dut_rd[99]), 32'd99);
    end
    check_val("t2_fifo_empty", 32'(olen_valid), 32'h0);

    // 3: runt and oversize packets
    do_reset();
    send_packet(10, 0, 1, 1, 0);
    send_packet(MAXL + 1, 0, 1, 1, 0);
    idle(2);
    check_val("t3_drop_cnt", 32'(odrop_cnt), 32'd2);
    check_val("t3_pkt_cnt", 32'(opkt_cnt), 32'd0);
    check_val("t3_fifo_empty", 32'(olen_valid), 32'h0);
    // exactly max length still commits
    send_packet(MAXL, 0, 0, 1, 0);
    idle(2);
    check_val("t3_max_commit", 32'(opkt_cnt), 32'd1);

    // 4: buffer overflow with no reads, then reading frees space
    do_reset();
    repeat (3) send_packet(700, 0, 0, 1, 0);
    idle(2);
    check_val("t4_pkt_cnt", 32'(opkt_cnt), 32'd2);
    check_val("t4_drop_cnt", 32'(odrop_cnt), 32'd1);
    read_pkts(1);
    send_packet(700, 0, 0, 1, 0);
    idle(2);
    check_val("t4_pkt_after_read", 32'(opkt_cnt), 32'd3);

    // 5: length FIFO full
    do_reset();
    repeat (17) send_packet(64, 0, 0, 1, 0);
    idle(2);
    check_val("t5_pkt_cnt", 32'(opkt_cnt), 32'd16);
    check_val("t5_drop_cnt", 32'(odrop_cnt), 32'd1);
    read_pkts(16);
    check_val("t5_drained", 32'(olen_valid), 32'h0);

    // 6: reset mid-packet and mid-read
    do_reset();
    send_packet(64, 0, 0, 1, 0);
    rd_target = m_popped + 1;
    rd_mode = 2;
    idle(12);
    send_packet(20, 0, 0, 0, 0);
    check_val("t6_busy_before", 32'(obusy_rd), 32'h1);
    rd_mode = 0;
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    idle(1);
    check_val("t6_ord_valid", 32'(ord_valid), 32'h0);
    check_val("t6_olen_valid", 32'(olen_valid), 32'h0);
    check_val("t6_busy", 32'(obusy_rd), 32'h0);
    check_val("t6_counts", 32'({opkt_cnt, odrop_cnt}), 32'h0);
    send_packet(64, 0, 1, 1, 0);
    idle(2);
    check_val("t6_pkt_cnt", 32'(opkt_cnt), 32'd1);
    dut_rd.delete();
    read_pkts(1);
    check_val("t6_rd_words", 32'(dut_rd.size()), 32'd64);

    // 7: randomized traffic with a concurrent random reader
    do_reset();
    rd_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int r, len;
      r = $urandom_range(0, 99);
      if (r < 20)      len = $urandom_range(1, MINL - 1);
      else if (r < 95) len = $urandom_range(MINL, 200);
      else             len = $urandom_range(MAXL + 1, MAXL + 6);
      send_packet(len, ($urandom_range(0, 9) == 0), 0, 1, 8);
      idle($urandom_range(0, 3));
    end
    idle(2);
    read_pkts(m_lenq.size());
    check_val("t7_drained", 32'(olen_valid), 32'h0);
    check_val("t7_idle", 32'(obusy_rd), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
